// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports and the data-memory port of mem_arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req0_valid;
  logic              req0_write;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              req0_ready;
  logic              resp0_valid;
  logic [DATA_W-1:0] resp0_rdata;

  logic              req1_valid;
  logic              req1_write;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic              req1_ready;
  logic              resp1_valid;
  logic [DATA_W-1:0] resp1_rdata;

  logic              MemWrite;
  logic              MemRead;
  logic [ADDR_W-1:0] read_address;
  logic [DATA_W-1:0] Write_data;
  logic [DATA_W-1:0] MemData_out;

  modport slave (
    input  req0_valid, req0_write, req0_addr, req0_wdata,
    input  req1_valid, req1_write, req1_addr, req1_wdata,
    input  MemData_out,
    output req0_ready, resp0_valid, resp0_rdata,
    output req1_ready, resp1_valid, resp1_rdata,
    output MemWrite, MemRead, read_address, Write_data
  );

  modport master (
    output req0_valid, req0_write, req0_addr, req0_wdata,
    output req1_valid, req1_write, req1_addr, req1_wdata,
    output MemData_out,
    input  req0_ready, resp0_valid, resp0_rdata,
    input  req1_ready, resp1_valid, resp1_rdata,
    input  MemWrite, MemRead, read_address, Write_data
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data memory.
// One access every 3 cycles: grant (IDLE), memory strobe (ACCESS), response (RESP).
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              idx_q, idx_d;

  logic              pick1;
  logic              ready0, ready1;
  logic              resp0, resp1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              mem_write, mem_read;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  // Next-state, arbitration and output decode
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    idx_d     = idx_q;
    pick1     = 1'b0;
    ready0    = 1'b0;
    ready1    = 1'b0;
    resp0     = 1'b0;
    resp1     = 1'b0;
    rdata0    = {DATA_W{1'b0}};
    rdata1    = {DATA_W{1'b0}};
    mem_write = 1'b0;
    mem_read  = 1'b0;
    mem_addr  = {ADDR_W{1'b0}};
    mem_wdata = {DATA_W{1'b0}};
    case (state_q)
      IDLE: begin
        // No acceptance while reset is high: the latch would be cleared anyway.
        if (!reset && (bus.req0_valid || bus.req1_valid)) begin
          pick1   = bus.req1_valid && (!bus.req0_valid || !last_q);
          ready0  = !pick1;
          ready1  = pick1;
          last_d  = pick1;
          idx_d   = pick1;
          write_d = pick1 ? bus.req1_write : bus.req0_write;
          addr_d  = pick1 ? bus.req1_addr  : bus.req0_addr;
          wdata_d = pick1 ? bus.req1_wdata : bus.req0_wdata;
          state_d = ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        mem_write = write_q;
        mem_read  = !write_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        state_d   = RESP;
      end
      RESP: begin
        if (idx_q) begin
          resp1  = 1'b1;
          rdata1 = write_q ? {DATA_W{1'b0}} : bus.MemData_out;
        end else begin
          resp0  = 1'b1;
          rdata0 = write_q ? {DATA_W{1'b0}} : bus.MemData_out;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and latched-request registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      write_q <= 1'b0;
      addr_q  <= {ADDR_W{1'b0}};
      wdata_q <= {DATA_W{1'b0}};
      idx_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.req0_ready   = ready0;
  assign bus.req1_ready   = ready1;
  assign bus.resp0_valid  = resp0;
  assign bus.resp1_valid  = resp1;
  assign bus.resp0_rdata  = rdata0;
  assign bus.resp1_rdata  = rdata1;
  assign bus.MemWrite     = mem_write;
  assign bus.MemRead      = mem_read;
  assign bus.read_address = mem_addr;
  assign bus.Write_data   = mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios then randomized traffic,
// all compared against a cycle-scheduled transaction model and a small memory.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .reset(reset), .bus(bus));

  // Environment memory, 16 words, aliased on the low address bits.
  logic [DW-1:0] env_mem [16];
  logic [DW-1:0] mem_rd;
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) env_mem[i] <= '0;
    end else if (bus.MemWrite) begin
      env_mem[bus.read_address[3:0]] <= bus.Write_data;
    end
    if (bus.MemRead) mem_rd <= env_mem[bus.read_address[3:0]];
  end
  assign bus.MemData_out = mem_rd;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Stimulus drive values
  logic          drv_rst;
  logic          drv_v [2];
  logic          drv_w [2];
  logic [AW-1:0] drv_a [2];
  logic [DW-1:0] drv_d [2];

  // Observations of the current cycle and history logs
  int            cyc = 0;
  logic          obs_ready [2];
  logic          obs_resp  [2];
  logic [DW-1:0] obs_rdata [2];
  logic          obs_mw, obs_mr;
  logic [AW-1:0] obs_addr;
  int            grant_idx_q [$];
  int            grant_cyc_q [$];
  int            resp_cnt [2];
  logic [DW-1:0] last_rdata [2];

  // Reference model: a granted transaction schedules its strobe at T+1,
  // its response at T+2, and the next grant no earlier than T+3.
  int            m_last = 1;
  int            m_free_at = 0;
  bit            m_has = 1'b0;
  int            m_t, m_idx;
  bit            m_w;
  logic [AW-1:0] m_a;
  logic [DW-1:0] m_d, m_rval;
  logic [DW-1:0] ref_mem [16];
  int            model_win;

  task automatic model_and_check();
    logic          e_ready [2];
    logic          e_resp  [2];
    logic [DW-1:0] e_rd    [2];
    logic          e_mw, e_mr;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    int            win;
    for (int i = 0; i < 2; i++) begin
      e_ready[i] = 1'b0; e_resp[i] = 1'b0; e_rd[i] = '0;
    end
    e_mw = 1'b0; e_mr = 1'b0; e_addr = '0; e_wd = '0; win = -1;
    if (m_has && cyc == m_t + 1) begin
      e_mw = m_w; e_mr = !m_w; e_addr = m_a; e_wd = m_d;
      if (m_w) ref_mem[m_a[3:0]] = m_d;
      else     m_rval = ref_mem[m_a[3:0]];
    end
    if (m_has && cyc == m_t + 2) begin
      e_resp[m_idx] = 1'b1;
      e_rd[m_idx]   = m_w ? '0 : m_rval;
      m_has = 1'b0;
    end
    if (!drv_rst && cyc >= m_free_at && (drv_v[0] || drv_v[1])) begin
      if (drv_v[0] && drv_v[1]) win = (m_last == 0) ? 1 : 0;
      else                      win = drv_v[0] ? 0 : 1;
      e_ready[win] = 1'b1;
      m_has = 1'b1; m_t = cyc; m_idx = win;
      m_w = drv_w[win]; m_a = drv_a[win]; m_d = drv_d[win];
      m_last = win; m_free_at = cyc + 3;
    end
    if (drv_rst) begin
      m_has = 1'b0; m_last = 1; m_free_at = cyc + 1;
      for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    end
    model_win = win;

    obs_ready[0] = bus.req0_ready;  obs_ready[1] = bus.req1_ready;
    obs_resp[0]  = bus.resp0_valid; obs_resp[1]  = bus.resp1_valid;
    obs_rdata[0] = bus.resp0_rdata; obs_rdata[1] = bus.resp1_rdata;
    obs_mw = bus.MemWrite; obs_mr = bus.MemRead; obs_addr = bus.read_address;

    check_eq("ready0", 64'(obs_ready[0]), 64'(e_ready[0]));
    check_eq("ready1", 64'(obs_ready[1]), 64'(e_ready[1]));
    check_eq("resp0_valid", 64'(obs_resp[0]), 64'(e_resp[0]));
    check_eq("resp1_valid", 64'(obs_resp[1]), 64'(e_resp[1]));
    check_eq("resp0_rdata", 64'(obs_rdata[0]), 64'(e_rd[0]));
    check_eq("resp1_rdata", 64'(obs_rdata[1]), 64'(e_rd[1]));
    check_eq("MemWrite", 64'(obs_mw), 64'(e_mw));
    check_eq("MemRead", 64'(obs_mr), 64'(e_mr));
    check_eq("read_address", 64'(obs_addr), 64'(e_addr));
    check_eq("Write_data", 64'(bus.Write_data), 64'(e_wd));

    for (int i = 0; i < 2; i++) begin
      if (obs_ready[i]) begin grant_idx_q.push_back(i); grant_cyc_q.push_back(cyc); end
      if (obs_resp[i]) begin resp_cnt[i]++; last_rdata[i] = obs_rdata[i]; end
    end
  endtask

  task automatic step();
    @(negedge clk);
    reset = drv_rst;
    bus.req0_valid = drv_v[0]; bus.req0_write = drv_w[0];
    bus.req0_addr  = drv_a[0]; bus.req0_wdata = drv_d[0];
    bus.req1_valid = drv_v[1]; bus.req1_write = drv_w[1];
    bus.req1_addr  = drv_a[1]; bus.req1_wdata = drv_d[1];
    #1;
    model_and_check();
    cyc++;
  endtask

  task automatic wait_ready(input int i);
    for (int k = 0; k < 12; k++) begin
      step();
      if (obs_ready[i]) return;
    end
    check_eq("grant_timeout", 64'(obs_ready[i]), 64'd1);
  endtask

  task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    drv_v[i] = 1'b1; drv_w[i] = w; drv_a[i] = a; drv_d[i] = d;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int rc;
    drv_rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drv_v[i] = 1'b0; drv_w[i] = 1'b0; drv_a[i] = '0; drv_d[i] = '0; resp_cnt[i] = 0;
    end
    repeat (3) step();
    drv_rst = 1'b0;
    step();

    // Single write
    set_req(0, 1'b1, 32'd0, 32'hDEADBEEF);
    wait_ready(0);
    drv_v[0] = 1'b0;
    step();
    check_eq("wr_memwrite", 64'(obs_mw), 64'd1);
    check_eq("wr_addr", 64'(obs_addr), 64'd0);
    check_eq("wr_wdata", 64'(bus.Write_data), 64'hDEADBEEF);
    step();
    check_eq("wr_resp0", 64'(obs_resp[0]), 64'd1);
    check_eq("wr_rdata0", 64'(obs_rdata[0]), 64'd0);
    step();

    // Read-back from the other requester
    rc = resp_cnt[0];
    set_req(1, 1'b0, 32'd0, 32'h0);
    wait_ready(1);
    drv_v[1] = 1'b0;
    step();
    check_eq("rb_memread", 64'(obs_mr), 64'd1);
    step();
    check_eq("rb_resp1", 64'(obs_resp[1]), 64'd1);
    check_eq("rb_rdata1", 64'(obs_rdata[1]), 64'hDEADBEEF);
    step();
    check_eq("rb_no_resp0", 64'(resp_cnt[0]), 64'(rc));

    // Contention
    grant_idx_q.delete(); grant_cyc_q.delete();
    set_req(0, 1'b1, 32'd5, 32'hCAFEBABE);
    set_req(1, 1'b0, 32'd5, 32'h0);
    wait_ready(1);
    drv_v[0] = 1'b0; drv_v[1] = 1'b0;
    check_eq("ct_ngrants", 64'(grant_idx_q.size()), 64'd2);
    if (grant_idx_q.size() >= 2) begin
      check_eq("ct_first", 64'(grant_idx_q[0]), 64'd0);
      check_eq("ct_second", 64'(grant_idx_q[1]), 64'd1);
      check_eq("ct_gap", 64'(grant_cyc_q[1] - grant_cyc_q[0]), 64'd3);
    end
    step();
    step();
    check_eq("ct_resp1", 64'(obs_resp[1]), 64'd1);
    check_eq("ct_rdata1", 64'(last_rdata[1]), 64'hCAFEBABE);
    step();

    // Fairness over 12 cycles of continuous contention
    grant_idx_q.delete(); grant_cyc_q.delete();
    set_req(0, 1'b0, 32'd1, 32'h0);
    set_req(1, 1'b0, 32'd2, 32'h0);
    repeat (12) step();
    drv_v[0] = 1'b0; drv_v[1] = 1'b0;
    check_eq("fair_ngrants", 64'(grant_idx_q.size()), 64'd4);
    for (int k = 0; k < grant_idx_q.size(); k++) begin
      check_eq("fair_order", 64'(grant_idx_q[k]), 64'(k % 2));
      if (k > 0) check_eq("fair_gap", 64'(grant_cyc_q[k] - grant_cyc_q[k-1]), 64'd3);
    end
    repeat (3) step();

    // Reset during the ACCESS cycle of a write
    set_req(0, 1'b1, 32'd7, 32'h12345678);
    wait_ready(0);
    drv_v[0] = 1'b0;
    drv_rst = 1'b1;
    rc = resp_cnt[0] + resp_cnt[1];
    step();
    drv_rst = 1'b0;
    set_req(1, 1'b0, 32'd7, 32'h0);
    step();
    check_eq("rst_memwrite", 64'(obs_mw), 64'd0);
    check_eq("rst_idle_grant", 64'(obs_ready[1]), 64'd1);
    check_eq("rst_no_resp", 64'(resp_cnt[0] + resp_cnt[1]), 64'(rc));
    drv_v[1] = 1'b0;
    step();
    step();
    check_eq("rst_rd_after", 64'(obs_rdata[1]), 64'd0);
    step();

    // Payload changes after acceptance must not affect the access
    set_req(0, 1'b0, 32'd3, 32'h0);
    wait_ready(0);
    drv_v[0] = 1'b0; drv_a[0] = 32'd9;
    step();
    check_eq("hold_addr", 64'(obs_addr), 64'd3);
    check_eq("hold_memread", 64'(obs_mr), 64'd1);
    repeat (2) step();

    // Randomized traffic with occasional resets
    for (int n = 0; n < 500; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!drv_v[i] && $urandom_range(0, 3) == 0) begin
          drv_v[i] = 1'b1;
          drv_w[i] = 1'($urandom_range(0, 1));
          drv_a[i] = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
          drv_d[i] = DW'($urandom);
        end
      end
      drv_rst = ($urandom_range(0, 49) == 0);
      step();
      for (int i = 0; i < 2; i++) begin
        if (model_win == i) begin
          drv_v[i] = 1'($urandom_range(0, 1));
          drv_w[i] = 1'($urandom_range(0, 1));
          drv_a[i] = AW'($urandom_range(0, 15));
          drv_d[i] = DW'($urandom);
        end
      end
    end
    drv_rst = 1'b0; drv_v[0] = 1'b0; drv_v[1] = 1'b0;
    repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
